// File: rtl/mem_pkg.sv
// Shared constants and types for the banked main-memory responder.
package mem_pkg;
   localparam int BUSY_CYCLES  = 4;
   localparam int RD_LATENCY   = 2;
   localparam int NUM_BANKS    = 4;
   localparam int BANK_SEL_LSB = 1;
   localparam int BANK_SEL_W   = $clog2(NUM_BANKS);
   localparam int CNT_W        = $clog2(BUSY_CYCLES + 1);

   typedef logic [BANK_SEL_W-1:0] bank_sel_t;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_READ,
      OP_WRITE
   } op_t;
endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller and the memory model.
interface banked_mem_responder_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    data_in;
   logic                 rd;
   logic                 wr;
   logic [DATA_W-1:0]    data_out;
   logic [NUM_BANKS-1:0] busy;
   logic                 stall;
   logic                 err;

   modport master (
      output addr, data_in, rd, wr,
      input  data_out, busy, stall, err
   );

   modport slave (
      input  addr, data_in, rd, wr,
      output data_out, busy, stall, err
   );
endinterface

// File: rtl/mem_bank.sv
// One memory bank: storage, occupancy down-counter and read-return pipeline.
module mem_bank
   import mem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0]     mem [2**IDX_W];
   logic [CNT_W-1:0]      cnt;
   logic [RD_LATENCY-1:0] vld;
   logic [DATA_W-1:0]     pipe [RD_LATENCY];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (acc && we) mem[idx] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (acc) begin
         cnt <= CNT_W'(BUSY_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      end else begin
         vld[0] <= acc && !we;
         if (acc && !we) pipe[0] <= mem[idx];
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i]  <= vld[i-1];
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign busy  = (cnt != '0);
   assign rdata = vld[RD_LATENCY-1] ? pipe[RD_LATENCY-1] : '0;
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank fixed-latency memory model; bank decode, accept and read merge.
// Define MEM_ERR_CHECK_EN to reject rd&wr and odd byte addresses via err.
module banked_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int WORDS_PER_BANK = 256
) (
   input logic                   clk,
   input logic                   rst,
   banked_mem_responder_if.slave bus
);
   localparam int IDX_W   = $clog2(WORDS_PER_BANK);
   localparam int IDX_LSB = BANK_SEL_LSB + BANK_SEL_W;

   bank_sel_t            bank;
   logic [IDX_W-1:0]     idx;
   logic                 req;
   logic                 bank_busy;
   logic                 err;
   op_t                  op;
   logic [NUM_BANKS-1:0] busy;
   logic [DATA_W-1:0]    rdata [NUM_BANKS];
   logic [DATA_W-1:0]    dout;
   logic                 unused_addr;

   assign bank      = bus.addr[BANK_SEL_LSB +: BANK_SEL_W];
   assign idx       = bus.addr[IDX_LSB +: IDX_W];
   assign req       = bus.rd | bus.wr;
   assign bank_busy = busy[bank];

   // Upper bits alias; bit 0 only matters when error checking is built in.
   assign unused_addr = ^{bus.addr[ADDR_W-1:IDX_LSB+IDX_W], bus.addr[0]};

`ifdef MEM_ERR_CHECK_EN
   assign err = (bus.rd & bus.wr) | (req & bus.addr[0]);
`else
   assign err = 1'b0;
`endif

   // With checking off, rd&wr falls through to a plain write.
   always_comb begin
      op = OP_NONE;
      if (!err && !bank_busy) begin
         if (bus.wr) begin
            op = OP_WRITE;
         end else if (bus.rd) begin
            op = OP_READ;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      mem_bank #(
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .acc   ((op != OP_NONE) && (bank == bank_sel_t'(b))),
         .we    (op == OP_WRITE),
         .idx   (idx),
         .wdata (bus.data_in),
         .busy  (busy[b]),
         .rdata (rdata[b])
      );
   end

   always_comb begin
      dout = '0;
      for (int b = 0; b < NUM_BANKS; b++) dout |= rdata[b];
   end

   assign bus.data_out = dout;
   assign bus.busy     = busy;
   assign bus.stall    = req & bank_busy;
   assign bus.err      = err;
endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Four-bank, fixed-latency main-memory model that answers the cache controller's `mem_rd`/`mem_wr` requests. It sits between the cache controller and nothing else.

- Decodes the bank from the word address.
- Keeps each bank busy for a fixed number of cycles after every access.
- Returns read data a fixed number of cycles after acceptance.
- Reports per-bank busy, stall and request errors back to the controller.

## Interface
- `ADDR_W`, 16, byte-address width.
- `DATA_W`, 16, word width.
- `WORDS_PER_BANK`, 256, storage depth of each bank (power of two).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `addr`  in  `ADDR_W`  byte address. `addr[2:1]` selects the bank; `addr[2+log2(WORDS_PER_BANK):3]` is the word index.
- `data_in`  in  `DATA_W`  write data.
- `rd`  in  1  read request.
- `wr`  in  1  write request.
- `data_out`  out  `DATA_W`  read data; valid only in the return cycle, 0 otherwise.
- `busy`  out  4  per-bank busy, registered.
- `stall`  out  1  request targets a busy bank (combinational).
- `err`  out  1  illegal request (combinational).

## Operation
- **Request.** A request exists in a cycle when `rd|wr`.
- **Accept.** A request is accepted at the rising edge ending cycle N when all of the following hold:
  - `rd^wr`
  - `!busy[bank]`
  - `!err`
  - At most one accept per cycle; the single request port enforces this.
- **Write accept.** `data_in` is stored into `bank[addr[2:1]][index]` at the accepting edge.
- **Read accept.** The stored word is captured into a per-bank read pipeline. It appears on `data_out` during cycle N+2.
- **Busy.** Each bank has a down-counter.
  - On accept it loads `BUSY_CYCLES`=4.
  - `busy[b]` = (counter != 0), so `busy[b]` is high in cycles N+1..N+4.
  - The same bank can be accepted again with a request presented in cycle N+5.
  - Other banks are independent: the controller may issue banks 0,1,2,3 in four consecutive cycles.
- **Stall.** `stall` = `(rd|wr) & busy[addr[2:1]]`. A stalled request is not accepted and has no side effects; the requester holds the request and retries.
- **Error.** `err` = `(rd & wr) | ((rd|wr) & addr[0])`. An errored request is not accepted: no write, no busy, no read data. `stall` and `err` may both be high.
- **Read return.**
  - Reads accepted in consecutive cycles, necessarily to different banks, return in consecutive cycles; `data_out` never collides.
  - `data_out` is the OR/mux of the pipeline stage with its valid bit set.
  - When no valid bit is set, `data_out` = 0.
- **Address range.** Address bits above the index field are ignored; addresses alias modulo bank size.
- **Reset.**
  - Clears all busy counters, pipeline valid bits and pipeline data.
  - Storage contents are not reset; simulation initialises them to 0.
  - Reset mid-operation drops any pending read; `data_out`=0 from reset onward.

## Timing
- Reset values:
  - `busy`=4'b0000
  - `data_out`=0
  - `stall`, `err` follow inputs combinationally, so they are 0 when `rd`=`wr`=0.
- Read latency: 2 cycles from accepting edge to the cycle `data_out` is valid; valid for exactly 1 cycle.
- Write visibility: a read to the same word accepted at a later edge returns the new data.
- Bank occupancy: 4 cycles after accept, then free.
- Busy to stall: `stall` reflects `busy` in the same cycle; no bypass of a bank freeing in the current cycle.

## Configuration
- **`MEM_ERR_CHECK_EN` defined:**
  - `err` as specified.
  - Errored requests are rejected.
- **`MEM_ERR_CHECK_EN` not defined:**
  - `err` is tied to 0 and `addr[0]` is ignored.
  - `rd & wr` together is treated as a write; no read data is returned.
  - Accept condition reduces to `(rd|wr) & !busy[bank]`.

## Structure
- Shared package `mem_pkg` holds:
  - `BUSY_CYCLES`=4
  - `RD_LATENCY`=2
  - `NUM_BANKS`=4
  - `BANK_SEL_LSB`=1
- Sub-module `mem_bank`, instantiated 4 times. Each instance contains:
  - storage array
  - busy down-counter
  - 2-stage read pipeline with valid bits
  - inputs: accept strobe, write enable, index, write data
- Top level: bank decode, accept/stall/err logic, `data_out` merge.

## Test plan
- **Reset.** Assert `rst` mid-read (read to 0x0010 accepted, `rst` in N+1). Expect `data_out`=0 in N+2 and `busy`=0 immediately.
- **Write then read.** Write 0xBEEF to 0x0008 in cycle 0, then read 0x0008 in cycle 5. Expect `data_out`=0xBEEF in cycle 7 only, and `busy[0]` high in cycles 1..4.
- **Bank interleave.** Reads to 0x0000, 0x0002, 0x0004, 0x0006 in cycles 0..3, preloaded with 1, 2, 3, 4. Expect `data_out` 1, 2, 3, 4 in cycles 2..5, no stall, and `busy`=4'b1111 in cycle 4.
- **Busy conflict.** Write to 0x0002 in cycle 0, then a read to 0x000A held in cycles 1..5.
  - `stall`=1 in cycles 1..4; accepted in cycle 5.
  - `data_out` valid in cycle 7.
  - No storage change while stalled.
- **Errors (with `MEM_ERR_CHECK_EN`).**
  - `wr` to 0x0003 → `err`=1, `busy` stays 0, storage unchanged.
  - `rd`&`wr` to 0x0004 → `err`=1, no `data_out`.
  - Without the macro: `err`=0 and the write to 0x0003 lands at 0x0002.
- **Alias.** With `WORDS_PER_BANK`=256, write 0x1234 to 0x0800, then read 0x0000. Expect 0x1234.
